// File: rtl/prog_clock_div.sv
// Purpose: programmable clock divider, 50% duty output for even and odd divisors.
// Latency: out_clock is driven straight from registers; a new divisor takes effect at the next period boundary.
// Backpressure: none. load is a single-cycle strobe and is never refused; a newer load overwrites an older pending one.
//
// Ports:
//   clock      source clock
//   rst        asynchronous, active-high reset
//   en         run request, sampled on posedge clock
//   div        requested divisor N (0 and 1 are clamped to 2)
//   load       single-cycle strobe that captures div
//   out_clock  divided clock
//   active     divider running
//   pending    a captured divisor is waiting for a period boundary
//   cur_div    divisor currently applied
//   tick       (only with PROG_CLOCK_DIV_TICK_EN) one-cycle pulse on each
//              wrap of the period counter that keeps the divider running
//
// Build option: define PROG_CLOCK_DIV_TICK_EN to add the tick output.
module prog_clock_div #(
  parameter int WIDTH   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             load,
  output logic             out_clock,
  output logic             active,
  output logic             pending,
  output logic [WIDTH-1:0] cur_div
`ifdef PROG_CLOCK_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEF_DIV);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic             r_active;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_cur_div;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_pending;
  // The posedge phase p is held as two mode-qualified copies. Exactly one of
  // them can be set at a time, so the output OR/AND below never sees two
  // register bits switching on the same edge, even when the divisor changes
  // parity at a boundary (where p rises and the mode flips together).
  logic             r_p_even;
  logic             r_p_odd;
  // Negedge copy of p; delays the odd-mode rising edge by half a cycle.
  logic             r_n;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  logic             w_last;
  logic             w_wrap;
  logic             w_apply;
  logic [WIDTH-1:0] w_cur_div_nxt;
  logic [WIDTH:0]   w_half;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_active_nxt;
  logic             w_p_nxt;
  logic [WIDTH-1:0] w_div_clamped;

  always_comb begin
    // Period boundary: last count of the current period while running.
    w_last = (r_cnt == (r_cur_div - ONE));
    w_wrap = r_active & w_last;

    // A pending divisor is applied at a boundary, or on any edge while idle.
    // The pending value used here is the one held before this edge, so a
    // load landing on the boundary edge waits for the following boundary.
    w_apply       = r_pending & (w_wrap | ~r_active);
    w_cur_div_nxt = w_apply ? r_pend_div : r_cur_div;

    // H = ceil(N/2), computed one bit wider so N = 2^WIDTH-1 cannot overflow.
    w_half    = ({1'b0, r_cur_div} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    w_cnt_inc = r_cnt + ONE;

    w_div_clamped = (div < TWO) ? TWO : div;

    w_cnt_nxt    = '0;
    w_active_nxt = 1'b0;
    w_p_nxt      = 1'b0;

    if (r_active) begin
      if (w_wrap) begin
        // Start of a new period, or a clean stop when en has dropped. In
        // both cases the count restarts at 0, and p (next cnt < H) is 1
        // exactly when another period follows.
        w_cnt_nxt    = '0;
        w_active_nxt = en;
        w_p_nxt      = en;
      end else begin
        // Mid-period: en is ignored so the current period always completes.
        // No wrap means cnt+1 <= N-1, so the increment cannot overflow.
        w_cnt_nxt    = w_cnt_inc;
        w_active_nxt = 1'b1;
        w_p_nxt      = ({1'b0, w_cnt_inc} < w_half);
      end
    end else begin
      // Idle: start a period on the first edge that sees en.
      w_cnt_nxt    = '0;
      w_active_nxt = en;
      w_p_nxt      = en;
    end
  end

  // ---------------------------------------------------------------------
  // Posedge registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_cnt     <= '0;
      r_cur_div <= DEF_DIV_W;
      r_p_even  <= 1'b0;
      r_p_odd   <= 1'b0;
    end else begin
      r_active  <= w_active_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_div <= w_cur_div_nxt;
      // Mode follows the divisor in force for the coming cycle; it only
      // differs from the current one across a boundary.
      r_p_even  <= w_p_nxt & ~w_cur_div_nxt[0];
      r_p_odd   <= w_p_nxt &  w_cur_div_nxt[0];
    end
  end

  // Divisor capture. A load always wins over the clear, so a load on the
  // boundary edge leaves the new value pending while the older one applies.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_pend_div <= DEF_DIV_W;
      r_pending  <= 1'b0;
    end else if (load) begin
      r_pend_div <= w_div_clamped;
      r_pending  <= 1'b1;
    end else if (w_apply) begin
      r_pending  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Negedge register
  // ---------------------------------------------------------------------
  always_ff @(negedge clock or posedge rst) begin
    if (rst) begin
      r_n <= 1'b0;
    end else begin
      r_n <= r_p_even | r_p_odd;
    end
  end

  // Even N: high for H = N/2 cycles starting at the posedge.
  // Odd N:  p AND n rises at the negedge after p rises and falls with p at
  //         a posedge, giving H - 0.5 = N/2 cycles high.
  assign out_clock = r_p_even | (r_p_odd & r_n);
  assign active    = r_active;
  assign pending   = r_pending;
  assign cur_div   = r_cur_div;

`ifdef PROG_CLOCK_DIV_TICK_EN
  // One cycle high after each wrap that keeps the divider running. The
  // terminating wrap (en low) leaves the block idle, so it does not tick.
  logic r_tick;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap & en;
    end
  end

  assign tick = r_tick;
`endif

endmodule

// File: tb/tb_prog_clock_div.sv
module tb_prog_clock_div;

  localparam int W    = 8;
  localparam int DEFD = 2;

  logic         clock = 1'b0;
  logic         rst   = 1'b1;
  logic         en    = 1'b0;
  logic         load  = 1'b0;
  logic [W-1:0] div   = '0;
  logic         out_clock;
  logic         active;
  logic         pending;
  logic [W-1:0] cur_div;
`ifdef PROG_CLOCK_DIV_TICK_EN
  logic         tick;
`endif

  int n_checks = 0;
  int n_errors = 0;

  prog_clock_div #(.WIDTH(W), .DEF_DIV(DEFD)) dut (
    .clock    (clock),
    .rst      (rst),
    .en       (en),
    .div      (div),
    .load     (load),
    .out_clock(out_clock),
    .active   (active),
    .pending  (pending),
    .cur_div  (cur_div)
`ifdef PROG_CLOCK_DIV_TICK_EN
    ,
    .tick     (tick)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: the divider is a sequence of periods of N cycles.
  // Within a period, counted in half-cycles t2 = 2*k + half, the output is
  // high for exactly N half-cycles, shifted by one half-cycle when N is odd.
  // ---------------------------------------------------------------------
  int m_active = 0;
  int m_k      = 0;
  int m_N      = DEFD;
  int m_pend   = 0;
  int m_pdiv   = DEFD;
  int m_tick   = 0;
  int m_bound  = 0;

  task automatic compare(input int half);
    int   t2;
    logic e_out;
    t2    = 2 * m_k + half;
    e_out = (m_active != 0) && (t2 >= (m_N % 2)) && (t2 < m_N + (m_N % 2));
    chk("out_clock", {31'd0, out_clock}, {31'd0, e_out});
    chk("active",    {31'd0, active},    m_active);
    chk("pending",   {31'd0, pending},   m_pend);
    chk("cur_div",   {24'd0, cur_div},   m_N);
`ifdef PROG_CLOCK_DIV_TICK_EN
    chk("tick",      {31'd0, tick},      m_tick);
`endif
  endtask

  always @(posedge clock) begin
    if (rst) begin
      m_active = 0; m_k = 0; m_N = DEFD; m_pend = 0; m_pdiv = DEFD; m_tick = 0;
    end else begin
      m_bound = (m_active != 0 && m_k == m_N - 1) ? 1 : 0;
      m_tick  = (m_bound != 0 && en) ? 1 : 0;
      if (m_pend != 0 && (m_bound != 0 || m_active == 0)) begin
        m_N    = m_pdiv;
        m_pend = 0;
      end
      if (m_active != 0) begin
        if (m_bound != 0) begin
          m_k      = 0;
          m_active = en ? 1 : 0;
        end else begin
          m_k++;
        end
      end else if (en) begin
        m_active = 1;
        m_k      = 0;
      end
      if (load) begin
        m_pdiv = (div < 2) ? 2 : int'(div);
        m_pend = 1;
      end
    end
    #1 compare(0);
    @(negedge clock);
    #1 compare(1);
  end

  // ---------------------------------------------------------------------
  // out_clock edge statistics (times in simulation units, clock period 10)
  // ---------------------------------------------------------------------
  longint last_rise = 0;
  bit     have_rise = 1'b0;
  int     n_rise    = 0;
  longint last_hi   = 0;
  longint min_hi, max_hi, min_per, max_per;

  task automatic clear_stats();
    n_rise  = 0;
    min_hi  = 64'd1000000; max_hi  = 0;
    min_per = 64'd1000000; max_per = 0;
  endtask

  always @(posedge out_clock) begin
    longint per;
    if (have_rise) begin
      per = longint'($time) - last_rise;
      if (per < min_per) min_per = per;
      if (per > max_per) max_per = per;
    end
    last_rise = longint'($time);
    have_rise = 1'b1;
    n_rise++;
  end

  always @(negedge out_clock) begin
    if (have_rise) begin
      last_hi = longint'($time) - last_rise;
      if (last_hi < min_hi) min_hi = last_hi;
      if (last_hi > max_hi) max_hi = last_hi;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus: inputs change 2 units after a negedge
  // ---------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #2;
  endtask

  task automatic wait_k(input int k, input int n);
    int i;
    i = 0;
    while (i < 100 && !(m_active != 0 && m_k == k && m_N == n)) begin
      step(1);
      i++;
    end
    n_checks++;
    if (i == 100) begin
      n_errors++;
      $display("FAIL wait_k: cnt %0d of N=%0d not reached within 100 cycles (at cnt %0d N=%0d)", k, n, m_k, m_N);
    end
  endtask

  task automatic chk_periodic(input string name, input longint per, input longint hi);
    chk({name, "_min_period"}, 32'(min_per), 32'(per));
    chk({name, "_max_period"}, 32'(max_per), 32'(per));
    chk({name, "_min_high"},   32'(min_hi),  32'(hi));
    chk({name, "_max_high"},   32'(max_hi),  32'(hi));
  endtask

  initial begin
    int ticks;
    clear_stats();

    // Reset state
    step(3);
    chk("rst_out_clock", {31'd0, out_clock}, 0);
    chk("rst_active",    {31'd0, active},    0);
    chk("rst_pending",   {31'd0, pending},   0);
    chk("rst_cur_div",   {24'd0, cur_div},   DEFD);
    rst = 1'b0;
    step(1);

    // N=4 loaded while idle, then run
    load = 1'b1; div = 8'd4;
    step(1);
    load = 1'b0;
    chk("idle_load_pending", {31'd0, pending}, 1);
    chk("idle_load_hold",    {24'd0, cur_div}, 2);
    step(1);
    chk("idle_apply_div",     {24'd0, cur_div}, 4);
    chk("idle_apply_pending", {31'd0, pending}, 0);
    en = 1'b1;
    clear_stats();
    step(30);
    chk("n4_active", {31'd0, active}, 1);
    chk("n4_rises",  n_rise, 8);
    chk_periodic("n4", 40, 20);

    // N=5: rise at negedge, fall at posedge, 2.5 cycles high
    load = 1'b1; div = 8'd5;
    step(1);
    load = 1'b0;
    step(9);
    clear_stats();
    step(50);
    chk("n5_rises", n_rise, 10);
    chk_periodic("n5", 50, 25);

    // N=6 running, load 3 at cnt=2: period completes, then N=3
    load = 1'b1; div = 8'd6;
    step(1);
    load = 1'b0;
    wait_k(2, 6);
    load = 1'b1; div = 8'd3;
    step(1);
    load = 1'b0;
    chk("n6_mid_pending", {31'd0, pending}, 1);
    chk("n6_mid_div",     {24'd0, cur_div}, 6);
    step(2);
    chk("n6_end_pending", {31'd0, pending}, 1);
    chk("n6_end_div",     {24'd0, cur_div}, 6);
    step(1);
    chk("n3_bound_pending", {31'd0, pending}, 0);
    chk("n3_bound_div",     {24'd0, cur_div}, 3);
    step(3);
    clear_stats();
    step(30);
    chk("n3_rises", n_rise, 10);
    chk_periodic("n3", 30, 15);

    // Divisor 0 clamps to 2
    load = 1'b1; div = 8'd0;
    step(1);
    load = 1'b0;
    chk("clamp_pending", {31'd0, pending}, 1);
    step(4);
    chk("clamp_div", {24'd0, cur_div}, 2);

    // N=8, en dropped at cnt=1: period finishes, then quiet
    load = 1'b1; div = 8'd8;
    step(1);
    load = 1'b0;
    wait_k(1, 8);
    en = 1'b0;
    clear_stats();
    step(6);
    chk("stop_still_active", {31'd0, active}, 1);
    step(1);
    chk("stop_active",    {31'd0, active},    0);
    chk("stop_out_clock", {31'd0, out_clock}, 0);
    chk("stop_last_high", 32'(last_hi), 40);
    step(10);
    chk("stop_no_rise", n_rise, 0);

    // Reset while out_clock is high mid-period with a divisor pending
    en = 1'b1;
    step(1);
    load = 1'b1; div = 8'd10;
    step(1);
    load = 1'b0;
    chk("pre_rst_out_clock", {31'd0, out_clock}, 1);
    chk("pre_rst_pending",   {31'd0, pending},   1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_clock", {31'd0, out_clock}, 0);
    chk("mid_rst_active",    {31'd0, active},    0);
    chk("mid_rst_pending",   {31'd0, pending},   0);
    chk("mid_rst_cur_div",   {24'd0, cur_div},   DEFD);
    step(2);
    rst = 1'b0;
    step(1);
    chk("post_rst_active",  {31'd0, active},  1);
    chk("post_rst_cur_div", {24'd0, cur_div}, DEFD);

    // N=7: 3.5 cycles high, one tick per period
    load = 1'b1; div = 8'd7;
    step(1);
    load = 1'b0;
    step(10);
    clear_stats();
    ticks = 0;
    for (int i = 0; i < 70; i++) begin
      step(1);
`ifdef PROG_CLOCK_DIV_TICK_EN
      if (tick === 1'b1) ticks++;
`endif
    end
`ifdef PROG_CLOCK_DIV_TICK_EN
    chk("n7_tick_count", ticks, 10);
`endif
    chk("n7_rises", n_rise, 10);
    chk_periodic("n7", 70, 35);

    en = 1'b0;
    step(12);
    chk("final_active", {31'd0, active}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_clock_div.md
PROG_CLOCK_DIV -- requirements
Module: prog_clock_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: width of the divisor and counter.
REQ-002 The block SHALL have parameter DEF_DIV, default 2: divisor applied out of reset (legal range 2..2^WIDTH-1).
REQ-003 The block SHALL have port clock  input  1  source clock.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port en  input  1  run request, sampled on posedge clock.
REQ-006 The block SHALL have port div  input  WIDTH  requested divisor N.
REQ-007 The block SHALL have port load  input  1  single-cycle strobe capturing div.
REQ-008 The block SHALL have port out_clock  output  1  divided clock, 50% duty for even and odd N.
REQ-009 The block SHALL have port active  output  1  divider running.
REQ-010 The block SHALL have port pending  output  1  captured divisor not yet applied.
REQ-011 The block SHALL have port cur_div  output  WIDTH  divisor currently applied.

Function
REQ-012 The block SHALL run posedge counter cnt over 0..cur_div-1 while active, wrapping N-1 -> 0; the wrap is the period boundary.
REQ-013 The block SHALL use H = ceil(N/2) and registered phase p = (next cnt < H), so p is high for H of every N posedges.
REQ-014 The block SHALL update negedge register n <= p every negedge clock.
REQ-015 The block SHALL drive out_clock = p for even N and p AND n for odd N, giving a high time of N/2 source periods in both cases.
REQ-016 The block SHALL select even/odd mode from cur_div bit 0 only, and that selection SHALL change only at a period boundary.
REQ-017 On a posedge with load=1, the block SHALL capture div into a pending register and set pending=1 on the same edge.
REQ-018 A captured div of 0 or 1 SHALL be clamped to 2.
REQ-019 The pending divisor SHALL be copied to cur_div at the next period boundary (or immediately when idle), and pending SHALL clear on that edge.
REQ-020 A load while pending=1 SHALL overwrite the pending value; only the last one SHALL be applied.
REQ-021 A load on the boundary edge itself SHALL be deferred to the following boundary.
REQ-022 While idle with en=1 at a posedge, the block SHALL set active=1, cnt=0 and p=1 on that edge; out_clock SHALL rise on that posedge (even N) or the next negedge (odd N).
REQ-023 Deassertion of en while active SHALL take effect only at the period boundary: the current period completes, then active=0, cnt=0, p=0, and out_clock stays low with no runt pulse.
REQ-024 When en is reasserted at that same boundary edge, the block SHALL continue without a gap.
REQ-025 out_clock SHALL be glitch-free in every case: no pulse shorter than min(H-0.5, N-H) source periods.

Reset
REQ-026 rst=1 SHALL asynchronously force cnt=0, p=0, n=0, active=0, pending=0, cur_div=DEF_DIV and out_clock=0, including mid-period.
REQ-027 After rst deasserts, the block SHALL resume normal operation on the first posedge with en=1.

Configuration
REQ-028 With macro PROG_CLOCK_DIV_TICK_EN defined, the block SHALL add output port tick (1 bit), high for exactly one source cycle, registered, on each posedge where cnt wraps N-1 -> 0 while active.
REQ-029 With PROG_CLOCK_DIV_TICK_EN defined, tick SHALL reset to 0 and SHALL be 0 while idle.
REQ-030 Without PROG_CLOCK_DIV_TICK_EN, the tick port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover: WIDTH=8, load div=4, en=1 -> out_clock period 4 clocks, high 2 clocks, active=1.
REQ-032 The bench SHALL cover: load div=5 -> period 5 clocks, high exactly 2.5 clocks (rise at negedge, fall at posedge), repeating for 10 periods.
REQ-033 The bench SHALL cover: running N=6, load div=3 at cnt=2 -> pending=1, the 6-clock period completes, then 3-clock periods, pending clears at the boundary, cur_div=3.
REQ-034 The bench SHALL cover: load div=0 -> cur_div=2; en dropped at cnt=1 of N=8 -> period finishes, active=0 at the boundary, out_clock low, no runt.
REQ-035 The bench SHALL cover: rst asserted while out_clock is high mid-period -> out_clock=0 immediately, cur_div=DEF_DIV, pending=0.
REQ-036 The bench SHALL cover: with PROG_CLOCK_DIV_TICK_EN, N=7 -> tick one cycle wide every 7 clocks, coincident with the cnt wrap.
